// File: rtl/ysyx_23060236_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_23060236_csr_pkg
//  Brief   : Shared CSR addresses, trap cause codes, mstatus bit positions
//            and csr_op encodings for the machine-mode CSR/trap unit.
//  Revision: 1.0  initial release
// ============================================================================
package ysyx_23060236_csr_pkg;

  // CSR addresses
  localparam logic [11:0] c_csr_mstatus   = 12'h300;
  localparam logic [11:0] c_csr_misa      = 12'h301;
  localparam logic [11:0] c_csr_mie       = 12'h304;
  localparam logic [11:0] c_csr_mtvec     = 12'h305;
  localparam logic [11:0] c_csr_mscratch  = 12'h340;
  localparam logic [11:0] c_csr_mepc      = 12'h341;
  localparam logic [11:0] c_csr_mcause    = 12'h342;
  localparam logic [11:0] c_csr_mtval     = 12'h343;
  localparam logic [11:0] c_csr_mip       = 12'h344;
  localparam logic [11:0] c_csr_satp      = 12'h180;
  localparam logic [11:0] c_csr_mcycle    = 12'hB00;
  localparam logic [11:0] c_csr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_csr_minstret  = 12'hB02;
  localparam logic [11:0] c_csr_minstreth = 12'hB82;
  localparam logic [11:0] c_csr_cycle     = 12'hC00;
  localparam logic [11:0] c_csr_cycleh    = 12'hC80;
  localparam logic [11:0] c_csr_instret   = 12'hC02;
  localparam logic [11:0] c_csr_instreth  = 12'hC82;
  localparam logic [11:0] c_csr_mvendorid = 12'hF11;
  localparam logic [11:0] c_csr_marchid   = 12'hF12;

  // csr_op encodings
  localparam logic [1:0] c_op_none  = 2'b00;
  localparam logic [1:0] c_op_write = 2'b01;
  localparam logic [1:0] c_op_set   = 2'b10;
  localparam logic [1:0] c_op_clear = 2'b11;

  // Exception cause codes
  localparam logic [4:0] c_cause_illegal    = 5'd2;
  localparam logic [4:0] c_cause_breakpoint = 5'd3;
  localparam logic [4:0] c_cause_ecall_m    = 5'd11;

  // Interrupt cause codes (also the mie/mip bit positions)
  localparam logic [4:0] c_irq_msi = 5'd3;
  localparam logic [4:0] c_irq_mti = 5'd7;
  localparam logic [4:0] c_irq_mei = 5'd11;

  // mstatus / mie / mip bit positions
  localparam int c_mstatus_mie_bit  = 3;
  localparam int c_mstatus_mpie_bit = 7;
  localparam int c_msi_bit          = 3;
  localparam int c_mti_bit          = 7;
  localparam int c_mei_bit          = 11;

  // Fixed read values
  localparam logic [31:0] c_misa_value = 32'h4000_1100;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060236_csr_counter.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_23060236_csr_counter
//  Brief   : 64-bit performance counter with increment enable and separate
//            low/high word write ports; a write replaces the increment.
//  Revision: 1.0  initial release
// ============================================================================
module ysyx_23060236_csr_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] r_count;

  // Counter register: a half-word write wins over the increment for the whole counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= 64'd0;
    end else if (wr_lo) begin
      r_count <= {r_count[63:32], wdata};
    end else if (wr_hi) begin
      r_count <= {wdata, r_count[31:0]};
    end else if (inc) begin
      r_count <= r_count + 64'd1;
    end
  end

  assign value = r_count;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060236_csr_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_23060236_csr_trap_unit
//  Brief   : Machine-mode CSR file with trap entry (interrupts, exceptions),
//            mret, and 64-bit cycle/instret counters. Redirects the IFU via
//            jump/jump_en in the retiring cycle.
//  Revision: 1.0  initial release
// ============================================================================
module ysyx_23060236_csr_trap_unit
  import ysyx_23060236_csr_pkg::*;
#(
  parameter logic [31:0] VENDOR_ID = 32'h7973_7978,
  parameter logic [31:0] ARCH_ID   = 32'h015f_df0c,
  parameter bit          HAS_SATP  = 1'b1,
  parameter bit          VECTORED  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        inst_ecall,
  input  logic        inst_ebreak,
  input  logic        inst_mret,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic [31:0] epc,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic [31:0] jump,
  output logic        jump_en,
  output logic        irq_taken,
  output logic        mmu_on
);

  localparam logic [1:0] c_mtvec_mode_mask = VECTORED ? 2'b11 : 2'b00;

  // Architectural state
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [2:0]  r_mie;          // {MEIE, MTIE, MSIE}
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:2] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  // Derived views and decode
  logic [31:0] w_mstatus;
  logic [31:0] w_mie;
  logic [31:0] w_mip;
  logic [31:0] w_mepc;
  logic [31:0] w_satp;
  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic [31:0] w_rdata;
  logic        w_exists;
  logic        w_read_only;
  logic        w_wr_intent;
  logic [31:0] w_wval;

  // Event decode
  logic        w_active;
  logic [31:0] w_irq_act;
  logic        w_take_irq;
  logic [4:0]  w_irq_cause;
  logic        w_take_exc;
  logic [4:0]  w_exc_cause;
  logic [31:0] w_exc_tval;
  logic        w_trap;
  logic        w_mret;
  logic        w_wr_en;
  logic        w_retire;
  logic [31:0] w_tvec_base;
  logic [31:0] w_trap_target;
  logic        w_unused;

  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mie     = {20'd0, r_mie[2], 3'd0, r_mie[1], 3'd0, r_mie[0], 3'd0};
  assign w_mip     = {20'd0, irq_ext, 3'd0, irq_timer, 3'd0, irq_sw, 3'd0};
  assign w_mepc    = {r_mepc, 2'b00};
  assign w_unused  = &{1'b0, epc[1:0]};

  // Read mux and address classification
  always_comb begin
    w_rdata     = 32'd0;
    w_exists    = 1'b1;
    w_read_only = 1'b0;
    case (csr_addr)
      c_csr_mstatus:   w_rdata = w_mstatus;
      c_csr_misa:      begin w_rdata = c_misa_value;       w_read_only = 1'b1; end
      c_csr_mie:       w_rdata = w_mie;
      c_csr_mtvec:     w_rdata = r_mtvec;
      c_csr_mscratch:  w_rdata = r_mscratch;
      c_csr_mepc:      w_rdata = w_mepc;
      c_csr_mcause:    w_rdata = r_mcause;
      c_csr_mtval:     w_rdata = r_mtval;
      c_csr_mip:       begin w_rdata = w_mip;              w_read_only = 1'b1; end
      c_csr_satp:      begin w_rdata = w_satp;             w_read_only = !HAS_SATP; end
      c_csr_mcycle:    w_rdata = w_mcycle[31:0];
      c_csr_mcycleh:   w_rdata = w_mcycle[63:32];
      c_csr_minstret:  w_rdata = w_minstret[31:0];
      c_csr_minstreth: w_rdata = w_minstret[63:32];
      c_csr_cycle:     begin w_rdata = w_mcycle[31:0];     w_read_only = 1'b1; end
      c_csr_cycleh:    begin w_rdata = w_mcycle[63:32];    w_read_only = 1'b1; end
      c_csr_instret:   begin w_rdata = w_minstret[31:0];   w_read_only = 1'b1; end
      c_csr_instreth:  begin w_rdata = w_minstret[63:32];  w_read_only = 1'b1; end
      c_csr_mvendorid: begin w_rdata = VENDOR_ID;          w_read_only = 1'b1; end
      c_csr_marchid:   begin w_rdata = ARCH_ID;            w_read_only = 1'b1; end
      default:         w_exists = 1'b0;
    endcase
  end

  // set/clear with a zero mask only reads, so it is legal on read-only CSRs
  assign w_wr_intent = (csr_op == c_op_write) || ((csr_op != c_op_none) && (csr_wdata != 32'd0));
  assign csr_illegal = (csr_op != c_op_none) && (!w_exists || (w_read_only && w_wr_intent));
  assign csr_rdata   = w_rdata;

  // New CSR value for write/set/clear
  always_comb begin
    w_wval = w_rdata;
    case (csr_op)
      c_op_write: w_wval = csr_wdata;
      c_op_set:   w_wval = w_rdata | csr_wdata;
      c_op_clear: w_wval = w_rdata & ~csr_wdata;
      default:    w_wval = w_rdata;
    endcase
  end

  // Event arbitration: interrupt > exception > mret > csr write
  assign w_active   = valid && !reset;
  assign w_irq_act  = w_mie & w_mip;
  assign w_take_irq = w_active && r_mstatus_mie && (w_irq_act != 32'd0);
  assign w_take_exc = w_active && !w_take_irq &&
                      (exc_valid || csr_illegal || inst_ebreak || inst_ecall);
  assign w_trap     = w_take_irq || w_take_exc;
  assign w_mret     = w_active && !w_trap && inst_mret;
  assign w_wr_en    = w_active && !w_trap && !w_mret && w_wr_intent;
  assign w_retire   = w_active && !w_trap;

  // Interrupt and exception cause selection
  always_comb begin
    w_irq_cause = c_irq_mti;
    if (w_irq_act[c_mei_bit]) begin
      w_irq_cause = c_irq_mei;
    end else if (w_irq_act[c_msi_bit]) begin
      w_irq_cause = c_irq_msi;
    end
    w_exc_cause = c_cause_ecall_m;
    w_exc_tval  = 32'd0;
    if (exc_valid) begin
      w_exc_cause = exc_cause;
      w_exc_tval  = exc_tval;
    end else if (csr_illegal) begin
      w_exc_cause = c_cause_illegal;
    end else if (inst_ebreak) begin
      w_exc_cause = c_cause_breakpoint;
    end
  end

  // Trap vector and IFU redirect
  assign w_tvec_base   = {r_mtvec[31:2], 2'b00};
  assign w_trap_target = (w_take_irq && VECTORED && (r_mtvec[1:0] == 2'b01))
                         ? w_tvec_base + {25'd0, w_irq_cause, 2'b00}
                         : w_tvec_base;
  assign jump_en   = w_trap || w_mret;
  assign jump      = w_trap ? w_trap_target : (w_mret ? w_mepc : 32'd0);
  assign irq_taken = w_take_irq;
  assign mmu_on    = !reset && w_satp[31];

  // Trap entry, mret and CSR writes to the machine-mode registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 3'd0;
      r_mtvec        <= 32'd0;
      r_mscratch     <= 32'd0;
      r_mepc         <= 30'd0;
      r_mcause       <= 32'd0;
      r_mtval        <= 32'd0;
    end else if (w_trap) begin
      r_mepc         <= epc[31:2];
      r_mcause       <= w_take_irq ? {1'b1, 26'd0, w_irq_cause} : {27'd0, w_exc_cause};
      r_mtval        <= w_take_irq ? 32'd0 : w_exc_tval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr_en) begin
      case (csr_addr)
        c_csr_mstatus: begin
          r_mstatus_mie  <= w_wval[c_mstatus_mie_bit];
          r_mstatus_mpie <= w_wval[c_mstatus_mpie_bit];
        end
        c_csr_mie:      r_mie      <= {w_wval[c_mei_bit], w_wval[c_mti_bit], w_wval[c_msi_bit]};
        c_csr_mtvec:    r_mtvec    <= {w_wval[31:2], w_wval[1:0] & c_mtvec_mode_mask};
        c_csr_mscratch: r_mscratch <= w_wval;
        c_csr_mepc:     r_mepc     <= w_wval[31:2];
        c_csr_mcause:   r_mcause   <= w_wval;
        c_csr_mtval:    r_mtval    <= w_wval;
        default: ;
      endcase
    end
  end

  generate
    if (HAS_SATP) begin : g_satp
      logic [31:0] r_satp;
      // satp register, written only by a legal CSR instruction
      always_ff @(posedge clock) begin
        if (reset) begin
          r_satp <= 32'd0;
        end else if (w_wr_en && (csr_addr == c_csr_satp)) begin
          r_satp <= w_wval;
        end
      end
      assign w_satp = r_satp;
    end else begin : g_no_satp
      assign w_satp = 32'd0;
    end
  endgenerate

  ysyx_23060236_csr_counter u_mcycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (w_wr_en && (csr_addr == c_csr_mcycle)),
    .wr_hi (w_wr_en && (csr_addr == c_csr_mcycleh)),
    .wdata (w_wval),
    .value (w_mcycle)
  );

  ysyx_23060236_csr_counter u_minstret (
    .clock (clock),
    .reset (reset),
    .inc   (w_retire),
    .wr_lo (w_wr_en && (csr_addr == c_csr_minstret)),
    .wr_hi (w_wr_en && (csr_addr == c_csr_minstreth)),
    .wdata (w_wval),
    .value (w_minstret)
  );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_csr_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ysyx_23060236_csr_trap_unit
//  Brief   : Self-checking bench: directed vector table, hand sequences for
//            counter carry and reset, randomized run against a CSR model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_ysyx_23060236_csr_trap_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        inst_ecall, inst_ebreak, inst_mret, exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_tval, epc;
  logic        irq_sw, irq_timer, irq_ext;
  logic [31:0] jump;
  logic        jump_en, irq_taken, mmu_on;

  int total = 0;
  int bad   = 0;

  ysyx_23060236_csr_trap_unit dut (
    .clock(clock), .reset(reset), .valid(valid), .csr_addr(csr_addr), .csr_op(csr_op),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .inst_ecall(inst_ecall), .inst_ebreak(inst_ebreak), .inst_mret(inst_mret),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .epc(epc),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .jump(jump), .jump_en(jump_en), .irq_taken(irq_taken), .mmu_on(mmu_on)
  );

  always #5 clock = ~clock;

  // ---------------- reference model state ----------------
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_satp;
  logic [63:0] m_cycle, m_instret;

  function automatic void m_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_satp = 0;
    m_cycle = 0; m_instret = 0;
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'h180, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
      12'hF11, 12'hF12: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ro(input logic [11:0] a);
    case (a)
      12'h301, 12'h344, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_1100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (irq_ext ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
      12'h180: return m_satp;
      12'hB00, 12'hC00: return m_cycle[31:0];
      12'hB80, 12'hC80: return m_cycle[63:32];
      12'hB02, 12'hC02: return m_instret[31:0];
      12'hB82, 12'hC82: return m_instret[63:32];
      12'hF11: return 32'h7973_7978;
      12'hF12: return 32'h015f_df0c;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare current outputs against the model, clock once, advance the model
  task automatic tick();
    logic [31:0] cur, nv, lines, act, tgt, e_jump;
    logic        wr_int, e_ill, is_irq, is_exc, is_mret, do_wr, retire;
    logic [4:0]  cause;
    logic [63:0] ncyc, nins;
    cur    = m_read(csr_addr);
    wr_int = (csr_op == 2'b01) || (csr_op != 2'b00 && csr_wdata != 0);
    e_ill  = (csr_op != 2'b00) && (!m_known(csr_addr) || (m_ro(csr_addr) && wr_int));
    lines  = (irq_ext ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_sw ? 32'h8 : 0);
    act    = lines & m_mie;
    is_irq  = valid && !reset && m_mstatus[3] && (act != 0);
    is_exc  = valid && !reset && !is_irq && (exc_valid || e_ill || inst_ecall || inst_ebreak);
    is_mret = valid && !reset && !is_irq && !is_exc && inst_mret;
    do_wr   = valid && !reset && !is_irq && !is_exc && !is_mret && wr_int;
    retire  = valid && !reset && !is_irq && !is_exc;
    if (is_irq)          cause = act[11] ? 5'd11 : (act[3] ? 5'd3 : 5'd7);
    else if (exc_valid)  cause = exc_cause;
    else if (e_ill)      cause = 5'd2;
    else if (inst_ebreak) cause = 5'd3;
    else                 cause = 5'd11;
    tgt = m_mtvec & ~32'd3;
    if (is_irq && m_mtvec[1:0] == 2'b01) tgt = tgt + 32'(cause) * 4;
    e_jump = (is_irq || is_exc) ? tgt : (is_mret ? m_mepc : 32'd0);
    case (csr_op)
      2'b01:   nv = csr_wdata;
      2'b10:   nv = cur | csr_wdata;
      2'b11:   nv = cur & ~csr_wdata;
      default: nv = cur;
    endcase
    chk("rdata",     {32'd0, csr_rdata}, {32'd0, cur});
    chk("illegal",   {63'd0, csr_illegal}, {63'd0, e_ill});
    chk("jump_en",   {63'd0, jump_en}, {63'd0, (is_irq || is_exc || is_mret)});
    chk("jump",      {32'd0, jump}, {32'd0, e_jump});
    chk("irq_taken", {63'd0, irq_taken}, {63'd0, is_irq});
    chk("mmu_on",    {63'd0, mmu_on}, {63'd0, (!reset && m_satp[31])});
    @(posedge clock);
    if (reset) begin
      m_reset();
    end else begin
      ncyc = m_cycle + 1;
      nins = m_instret + (retire ? 64'd1 : 64'd0);
      if (is_irq || is_exc) begin
        m_mepc    = epc & ~32'd3;
        m_mcause  = is_irq ? (32'h8000_0000 | 32'(cause)) : 32'(cause);
        m_mtval   = (is_exc && exc_valid) ? exc_tval : 32'd0;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (is_mret) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (do_wr) begin
        case (csr_addr)
          12'h300: m_mstatus  = (nv & 32'h88) | 32'h1800;
          12'h304: m_mie      = nv & 32'h888;
          12'h305: m_mtvec    = nv;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'd3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
          12'h180: m_satp     = nv;
          12'hB00: ncyc = {m_cycle[63:32], nv};
          12'hB80: ncyc = {nv, m_cycle[31:0]};
          12'hB02: nins = {m_instret[63:32], nv};
          12'hB82: nins = {nv, m_instret[31:0]};
          default: ;
        endcase
      end
      m_cycle   = ncyc;
      m_instret = nins;
    end
    #1;
  endtask

  task automatic set_idle();
    valid = 0; csr_addr = 0; csr_op = 0; csr_wdata = 0;
    inst_ecall = 0; inst_ebreak = 0; inst_mret = 0; exc_valid = 0;
    exc_cause = 5'd5; exc_tval = 32'hDEAD_BEEF; epc = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    set_idle(); csr_addr = a; #2;
    chk(name, {32'd0, csr_rdata}, {32'd0, exp});
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    set_idle(); valid = 1; csr_op = 2'b01; csr_addr = a; csr_wdata = d; #2;
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [3:0]  ev;      // {exc, mret, ebreak, ecall}
    logic [31:0] pc;
    logic [2:0]  irq;     // {ext, timer, sw}
    logic [31:0] e_rdata;
    logic        e_ill;
    logic        e_jen;
    logic [31:0] e_jump;
    logic        e_irq;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic v, input logic [11:0] a, input logic [1:0] op,
                              input logic [31:0] wd, input logic [3:0] ev, input logic [31:0] pc,
                              input logic [2:0] irq, input logic [31:0] rdv, input logic ill,
                              input logic jen, input logic [31:0] jmp, input logic ir);
    vec_t t;
    t.v = v; t.addr = a; t.op = op; t.wdata = wd; t.ev = ev; t.pc = pc; t.irq = irq;
    t.e_rdata = rdv; t.e_ill = ill; t.e_jen = jen; t.e_jump = jmp; t.e_irq = ir;
    return t;
  endfunction

  localparam logic [3:0] ECALL = 4'b0001, MRET = 4'b0100, EXC = 4'b1000;

  initial begin
    set_idle();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    m_reset();
    reset = 0;

    vt.push_back(mk(0, 12'h300, 0, 0, 0, 0, 0, 32'h0000_1800, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'h301, 0, 0, 0, 0, 0, 32'h4000_1100, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'hF11, 0, 0, 0, 0, 0, 32'h7973_7978, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'hF12, 0, 0, 0, 0, 0, 32'h015f_df0c, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h305, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h300, 2, 32'h8, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h341, 0, 0, ECALL, 32'h8000_0040, 0, 0, 0, 1, 32'h8000_0100, 0));
    vt.push_back(mk(0, 12'h341, 0, 0, 0, 0, 0, 32'h8000_0040, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'h342, 0, 0, 0, 0, 0, 32'd11, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'h300, 0, 0, 0, 0, 0, 32'h1880, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h300, 0, 0, MRET, 0, 0, 32'h1880, 0, 1, 32'h8000_0040, 0));
    vt.push_back(mk(0, 12'h300, 0, 0, 0, 0, 0, 32'h1888, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h304, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h305, 1, 32'h8000_0101, 0, 0, 0, 32'h8000_0100, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h300, 0, 0, 0, 32'h8000_0200, 3'b010, 32'h1888, 0, 1, 32'h8000_011C, 1));
    vt.push_back(mk(0, 12'h342, 0, 0, 0, 0, 0, 32'h8000_0007, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'hB02, 0, 0, 0, 0, 0, 32'd5, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'h341, 0, 0, 0, 0, 0, 32'h8000_0200, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h301, 2, 32'h1, 0, 32'h8000_0400, 0, 32'h4000_1100, 1, 1, 32'h8000_0100, 0));
    vt.push_back(mk(0, 12'h342, 0, 0, 0, 0, 0, 32'd2, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h301, 2, 32'h0, 0, 0, 0, 32'h4000_1100, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h7C0, 1, 32'h1234, 0, 32'h8000_0440, 0, 0, 1, 1, 32'h8000_0100, 0));
    vt.push_back(mk(1, 12'h343, 0, 0, EXC | ECALL, 32'h8000_0500, 0, 0, 0, 1, 32'h8000_0100, 0));
    vt.push_back(mk(0, 12'h342, 0, 0, 0, 0, 0, 32'd5, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'h343, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'hF11, 1, 32'h5, 0, 0, 0, 32'h7973_7978, 1, 1, 32'h8000_0100, 0));
    vt.push_back(mk(1, 12'h180, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 12'h180, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h300, 2, 32'h8, 0, 0, 0, 32'h1800, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h304, 1, 32'h888, 0, 0, 0, 32'h80, 0, 0, 0, 0));
    vt.push_back(mk(1, 12'h304, 0, 0, 0, 32'h8000_0600, 3'b111, 32'h888, 0, 1, 32'h8000_012C, 1));
    vt.push_back(mk(0, 12'h342, 0, 0, 0, 0, 0, 32'h8000_000B, 0, 0, 0, 0));

    foreach (vt[i]) begin
      set_idle();
      valid = vt[i].v; csr_addr = vt[i].addr; csr_op = vt[i].op; csr_wdata = vt[i].wdata;
      {exc_valid, inst_mret, inst_ebreak, inst_ecall} = vt[i].ev;
      epc = vt[i].pc;
      {irq_ext, irq_timer, irq_sw} = vt[i].irq;
      #2;
      chk($sformatf("v%0d_rdata", i), {32'd0, csr_rdata}, {32'd0, vt[i].e_rdata});
      chk($sformatf("v%0d_illegal", i), {63'd0, csr_illegal}, {63'd0, vt[i].e_ill});
      chk($sformatf("v%0d_jump_en", i), {63'd0, jump_en}, {63'd0, vt[i].e_jen});
      chk($sformatf("v%0d_jump", i), {32'd0, jump}, {32'd0, vt[i].e_jump});
      chk($sformatf("v%0d_irq_taken", i), {63'd0, irq_taken}, {63'd0, vt[i].e_irq});
      tick();
    end

    // Counter carry and write-overrides-increment
    wr(12'hB00, 32'hFFFF_FFFF);
    rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_carry", 12'hB80, 32'd1);
    rd("mcycle_after_carry", 12'hB00, 32'd1);
    wr(12'hB00, 32'h1234_5678);
    rd("mcycle_exact_write", 12'hB00, 32'h1234_5678);
    wr(12'hB82, 32'd2);
    wr(12'hB02, 32'hFFFF_FFFF);
    rd("minstret_exact_write", 12'hB02, 32'hFFFF_FFFF);
    set_idle(); valid = 1; #2; tick();
    rd("minstreth_carry", 12'hB82, 32'd3);
    rd("minstret_wrapped", 12'hB02, 32'd0);

    // Reset asserted in the middle of a trapping instruction
    wr(12'h340, 32'h55);
    set_idle(); reset = 1; valid = 1; inst_ecall = 1; epc = 32'h8000_0800; csr_addr = 12'h340; #2;
    chk("reset_jump_en", {63'd0, jump_en}, 64'd0);
    chk("reset_mmu_on", {63'd0, mmu_on}, 64'd0);
    tick();
    reset = 0;
    rd("post_reset_mcycle", 12'hB00, 32'd0);
    rd("post_reset_mscratch", 12'h340, 32'd0);
    rd("post_reset_mepc", 12'h341, 32'd0);
    rd("post_reset_mstatus", 12'h300, 32'h1800);
    rd("post_reset_satp", 12'h180, 32'd0);

    // Randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic [11:0] pool [0:11];
      int k;
      pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h343,
               12'h180, 12'hB00, 12'hB82, 12'hC02, 12'h7C0};
      set_idle();
      reset     = ($urandom_range(0, 99) == 0);
      valid     = ($urandom_range(0, 3) != 0);
      csr_addr  = pool[$urandom_range(0, 11)];
      csr_op    = 2'($urandom_range(0, 3));
      csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      k = $urandom_range(0, 15);
      inst_ecall  = (k == 0);
      inst_ebreak = (k == 1);
      inst_mret   = (k == 2) || (k == 3);
      exc_valid   = (k == 4);
      exc_cause   = 5'($urandom_range(0, 15));
      exc_tval    = $urandom;
      if (inst_ecall || inst_ebreak || exc_valid) csr_op = 2'b00;
      epc       = $urandom;
      irq_sw    = ($urandom_range(0, 7) == 0);
      irq_timer = ($urandom_range(0, 7) == 0);
      irq_ext   = ($urandom_range(0, 7) == 0);
      #2;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
